// File: rtl/pi_sched_pkg.sv
// Shared definitions for the PI theta core sequencer: FSM encoding,
// default timing constants and a constant-function clog2.
package pi_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StIssue,
        StWait,
        StNext
    } sched_state_e;

    localparam int unsigned DefLead  = 15;
    localparam int unsigned DefLat   = 27;
    localparam int unsigned DefToCyc = 63;

    // Bits needed to index v distinct values (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 1) ? v - 1 : 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi_sched_next_ch.sv
// Lowest-set-bit finder over the pending channel mask.
module pi_sched_next_ch #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = 2
) (
    input  logic [N_CH-1:0] pend_i,
    output logic [CW-1:0]   idx_o,
    output logic            valid_o
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                idx_o   = CW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pi_theta_sched.sv
// Time-shares one PI theta core among N_CH channels per simulation step.
// Each enabled channel, in ascending order: rd_x strobe, pi_sta LEAD cycles
// later, wait for pi_done, then commit via wr_en. All outputs registered.
// Optional watchdog on the core's done: define PI_SCHED_WDOG_EN.
module pi_theta_sched
    import pi_sched_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CW     = 2,
    parameter int unsigned LEAD   = DefLead,
    parameter int unsigned LAT    = DefLat,
    parameter int unsigned TO_CYC = DefToCyc
) (
    input  logic            clk,
    input  logic            rst_user,
    input  logic            step_start,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            pi_done,
    output logic            busy,
    output logic [CW-1:0]   ch_sel,
    output logic            rd_x,
    output logic            pi_sta,
    output logic            wr_en,
    output logic [CW-1:0]   wr_ch,
    output logic            step_done,
    output logic            err
);

    localparam int unsigned CntMax = (LEAD > TO_CYC) ? LEAD : TO_CYC;
    localparam int unsigned CntW   = clog2(CntMax + 1);
    localparam logic [CntW-1:0] LeadLoad = CntW'(LEAD - 1);

    // LAT is the core's nominal latency; the sequencer simply waits for done.
    if (N_CH < 2 || N_CH > 16 || LEAD < 2 || LAT < 1 || TO_CYC < 2 ||
        (1 << CW) < N_CH) begin : g_bad_param
        $error("pi_theta_sched: parameter out of range");
    end

    sched_state_e    state_q, state_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   ch_sel_q, ch_sel_d;
    logic [CW-1:0]   wr_ch_q, wr_ch_d;
    logic            busy_q, busy_d;
    logic            rd_x_q, rd_x_d;
    logic            pi_sta_q, pi_sta_d;
    logic            wr_en_q, wr_en_d;
    logic            step_done_q, step_done_d;

    logic [N_CH-1:0] cur_bit;
    logic [N_CH-1:0] find_in;
    logic [CW-1:0]   nx_idx;
    logic            nx_valid;

    assign cur_bit = {{(N_CH - 1){1'b0}}, 1'b1} << ch_sel_q;
    // In IDLE pick from the incoming mask; otherwise from what remains once
    // the channel in flight is retired.
    assign find_in = (state_q == StIdle) ? ch_mask : (pend_q & ~cur_bit);

    pi_sched_next_ch #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_next_ch (
        .pend_i  (find_in),
        .idx_o   (nx_idx),
        .valid_o (nx_valid)
    );

`ifdef PI_SCHED_WDOG_EN
    localparam logic [CntW-1:0] ToLast = CntW'(TO_CYC - 1);
    logic err_q, err_d;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        ch_sel_d    = ch_sel_q;
        wr_ch_d     = wr_ch_q;
        busy_d      = busy_q;
        rd_x_d      = 1'b0;
        pi_sta_d    = 1'b0;
        wr_en_d     = 1'b0;
        step_done_d = 1'b0;
`ifdef PI_SCHED_WDOG_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (step_start) begin
                    pend_d = ch_mask;
                    if (nx_valid) begin
                        state_d  = StLead;
                        rd_x_d   = 1'b1;
                        ch_sel_d = nx_idx;
                        cnt_d    = LeadLoad;
                        busy_d   = 1'b1;
                    end else begin
                        step_done_d = 1'b1;
                    end
                end
            end
            // NEXT is the first cycle of the following channel's lead time.
            StLead, StNext: begin
                if (cnt_q == '0) begin
                    state_d  = StIssue;
                    pi_sta_d = 1'b1;
                end else begin
                    state_d = StLead;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef PI_SCHED_WDOG_EN
                // cnt tracks cycles elapsed since pi_sta
                cnt_d   = CntW'(1);
`endif
            end
            StWait: begin
                if (pi_done) begin
                    pend_d  = pend_q & ~cur_bit;
                    wr_en_d = 1'b1;
                    wr_ch_d = ch_sel_q;
                    if (nx_valid) begin
                        state_d  = StNext;
                        rd_x_d   = 1'b1;
                        ch_sel_d = nx_idx;
                        cnt_d    = LeadLoad;
                    end else begin
                        state_d     = StIdle;
                        step_done_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
`ifdef PI_SCHED_WDOG_EN
                // Done on the last examined cycle still wins over the timeout.
                else if (cnt_q == ToLast) begin
                    state_d     = StIdle;
                    err_d       = 1'b1;
                    step_done_d = 1'b1;
                    busy_d      = 1'b0;
                    pend_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any step in flight.
    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            cnt_q       <= '0;
            ch_sel_q    <= '0;
            wr_ch_q     <= '0;
            busy_q      <= 1'b0;
            rd_x_q      <= 1'b0;
            pi_sta_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            ch_sel_q    <= ch_sel_d;
            wr_ch_q     <= wr_ch_d;
            busy_q      <= busy_d;
            rd_x_q      <= rd_x_d;
            pi_sta_q    <= pi_sta_d;
            wr_en_q     <= wr_en_d;
            step_done_q <= step_done_d;
        end
    end

`ifdef PI_SCHED_WDOG_EN
    // Sticky watchdog error.
    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = busy_q;
    assign ch_sel    = ch_sel_q;
    assign rd_x      = rd_x_q;
    assign pi_sta    = pi_sta_q;
    assign wr_en     = wr_en_q;
    assign wr_ch     = wr_ch_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_pi_theta_sched.sv
// Scoreboard bench for pi_theta_sched: expected strobe events are queued when
// a step is launched and compared against events recorded from the DUT.
module tb_pi_theta_sched;

    localparam int LEAD = 15;
    localparam int LAT  = 27;
    localparam int TOC  = 63;
    localparam int PER  = LEAD + LAT + 1;

    // kind: 0 wr_en, 1 step_done, 2 rd_x, 3 pi_sta
    typedef struct packed {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_user = 1'b1;
    logic       step_start = 1'b0;
    logic [3:0] ch_mask = 4'h0;
    logic       pi_done = 1'b0;
    logic       busy, rd_x, pi_sta, wr_en, step_done, err;
    logic [1:0] ch_sel, wr_ch;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  done_at = -1;
    int  core_lat = LAT;
    bit  core_en = 1'b1;
    bit  inject = 1'b0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    pi_theta_sched #(
        .N_CH   (4),
        .CW     (2),
        .LEAD   (LEAD),
        .LAT    (LAT),
        .TO_CYC (TOC)
    ) dut (
        .clk        (clk),
        .rst_user   (rst_user),
        .step_start (step_start),
        .ch_mask    (ch_mask),
        .pi_done    (pi_done),
        .busy       (busy),
        .ch_sel     (ch_sel),
        .rd_x       (rd_x),
        .pi_sta     (pi_sta),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .step_done  (step_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder and PI core model, evaluated mid-cycle.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_user) begin
            done_at = -1;
        end else begin
            if (wr_en) begin ev = '{0, cyc, int'(wr_ch)}; obs_q.push_back(ev); end
            if (step_done) begin ev = '{1, cyc, 0}; obs_q.push_back(ev); end
            if (rd_x) begin ev = '{2, cyc, int'(ch_sel)}; obs_q.push_back(ev); end
            if (pi_sta) begin
                ev = '{3, cyc, 0};
                obs_q.push_back(ev);
                if (core_en) done_at = cyc + core_lat;
            end
        end
        pi_done = (!rst_user && cyc == done_at) || inject;
    end

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_step(input logic [3:0] m, output int c0);
        ch_mask    = m;
        step_start = 1'b1;
        c0         = cyc;
        next_cycle(1);
        step_start = 1'b0;
    endtask

    // Queue the nominal schedule for a step launched in cycle c0.
    task automatic expect_step(input logic [3:0] m, input int c0);
        ev_t e;
        int  t;
        t = c0 + 1;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                e = '{2, t, ch};        exp_q.push_back(e);
                e = '{3, t + LEAD, 0};  exp_q.push_back(e);
                e = '{0, t + PER, ch};  exp_q.push_back(e);
                t += PER;
            end
        end
        e = '{1, t, 0};
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, want 0", busy);
        end
        n_tests++;
        if ({rd_x, pi_sta, wr_en, step_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, want 00000", {rd_x, pi_sta, wr_en, step_done, err});
        end
        n_tests++;
        if ({ch_sel, wr_ch} !== 4'b0) begin
            n_fail++; $display("FAIL reset_idx: got %b, want 0000", {ch_sel, wr_ch});
        end
        next_cycle(3);
        rst_user = 1'b0;
        next_cycle(2);
    endtask

    task automatic test_mask(input string name, input logic [3:0] m);
        int  c0;
        int  k;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        k = $countones(m);
        start_step(m, c0);
        expect_step(m, c0);
        n_tests++;
        if (busy !== (k != 0)) begin
            n_fail++; $display("FAIL %s_busy_rise: got %b, want %b", name, busy, k != 0);
        end
        next_cycle(k * PER + 4);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_fall: got %b, want 0", name, busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_event: got none, want kind %0d cyc %0d val %0d", name, e.kind, e.cyc, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             name, o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL %s_extra: got %0d extra events, want 0", name, obs_q.size());
        end
    endtask

    task automatic test_empty_mask();
        int c0;
        int hi;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        start_step(4'b0000, c0);
        e = '{1, c0 + 1, 0};
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0) hi++;
            next_cycle(1);
        end
        n_tests++;
        if (hi != 0) begin
            n_fail++; $display("FAIL empty_busy: got %0d cycles high, want 0", hi);
        end
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL empty_count: got %0d events, want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL empty_done: got kind %0d cyc %0d, want kind 1 cyc %0d", o.kind, o.cyc, e.cyc);
            end
        end
    endtask

    task automatic test_reset_mid_step();
        int c0;
        start_step(4'b1111, c0);
        next_cycle(19);
        rst_user = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b, want 0", busy);
        end
        n_tests++;
        if ({rd_x, pi_sta, wr_en, step_done, err, ch_sel, wr_ch} !== 9'b0) begin
            n_fail++;
            $display("FAIL midrst_outs: got %b, want 0", {rd_x, pi_sta, wr_en, step_done, err, ch_sel, wr_ch});
        end
        next_cycle(2);
        rst_user = 1'b0;
        next_cycle(1);
        test_mask("restart", 4'b1111);
    endtask

    task automatic test_back_to_back();
        int  c0;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        start_step(4'b1111, c0);
        expect_step(4'b1111, c0);
        next_cycle(4);
        ch_mask = 4'b0001; step_start = 1'b1;
        next_cycle(1);
        step_start = 1'b0; inject = 1'b1;
        next_cycle(1);
        inject = 1'b0;
        next_cycle(c0 + 50 - cyc);
        inject = 1'b1;
        next_cycle(1);
        inject = 1'b0;
        next_cycle(c0 + 4 * PER + 6 - cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_event: got none, want kind %0d cyc %0d val %0d", e.kind, e.cyc, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_missing_done();
        int  c0;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        core_en = 1'b0;
        start_step(4'b0001, c0);
        e = '{2, c0 + 1, 0};         exp_q.push_back(e);
        e = '{3, c0 + 1 + LEAD, 0};  exp_q.push_back(e);
`ifdef PI_SCHED_WDOG_EN
        e = '{1, c0 + 1 + LEAD + TOC, 0}; exp_q.push_back(e);
`endif
        next_cycle(LEAD + TOC + 20);
`ifdef PI_SCHED_WDOG_EN
        n_tests++;
        if ({busy, err} !== 2'b01) begin
            n_fail++; $display("FAIL wdog_state: got busy,err %b, want 01", {busy, err});
        end
`else
        n_tests++;
        if ({busy, err} !== 2'b10) begin
            n_fail++; $display("FAIL hang_state: got busy,err %b, want 10", {busy, err});
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL nodone_event: got none, want kind %0d cyc %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL nodone_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL nodone_extra: got %0d extra events, want 0", obs_q.size());
        end
        rst_user = 1'b1;
        next_cycle(2);
        rst_user = 1'b0;
        core_en  = 1'b1;
        next_cycle(1);
`ifdef PI_SCHED_WDOG_EN
        // Done on the last watched cycle must complete normally.
        exp_q.delete(); obs_q.delete();
        core_lat = TOC - 1;
        start_step(4'b0001, c0);
        next_cycle(LEAD + TOC + 10);
        e = '{0, c0 + 1 + LEAD + TOC, 0};
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL wdog_edge_count: got %0d events, want 4", obs_q.size());
        end else begin
            o = obs_q[2];
            if (o !== e || err !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_edge: got kind %0d cyc %0d err %b, want kind 0 cyc %0d err 0",
                         o.kind, o.cyc, err, e.cyc);
            end
        end
        core_lat = LAT;
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_mask("full", 4'b1111);
        test_mask("sparse", 4'b1010);
        test_empty_mask();
        test_reset_mid_step();
        test_back_to_back();
        test_missing_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pi_theta_sched.md
# pi_theta_sched

Sequencer that time-shares one 64-bit PI theta core (PI with ±2π wrap, fixed sta→done latency) among N_CH channels in each simulation step. For every enabled channel it selects the channel's state slot, pulses the core's read-ahead strobe, issues `sta` a fixed lead time later, waits for the core's done, then commits the result. It sits between the step controller and the shared PI core.

## Interface
- N_CH, 4, number of channels sharing the core (2..16)
- CW, 2, channel index width (clog2(N_CH))
- LEAD, 15, cycles from `rd_x` pulse to `pi_sta` pulse (core read-ahead requirement)
- LAT, 27, nominal core latency `pi_sta`→`pi_done`
- TO_CYC, 63, watchdog limit in cycles after `pi_sta` (used only with watchdog macro)

Ports:
- clk  in  1  clock
- rst_user  in  1  reset, asynchronous, active-high
- step_start  in  1  one-cycle request to run one step
- ch_mask  in  N_CH  enabled channels, sampled on accepted `step_start`
- pi_done  in  1  done pulse from PI core
- busy  out  1  step in progress
- ch_sel  out  CW  channel slot addressed in the core / x mux
- rd_x  out  1  read-ahead strobe to core (one cycle)
- pi_sta  out  1  start strobe to core (one cycle)
- wr_en  out  1  commit core output y for `wr_ch`
- wr_ch  out  CW  channel being committed
- step_done  out  1  one-cycle end-of-step pulse
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, LEAD, ISSUE, WAIT, NEXT.
- IDLE: `step_start`=1 latches `ch_mask` into `pend`; if `pend`≠0 go LEAD for lowest set channel, else pulse `step_done` next cycle and stay IDLE.
- LEAD entry: `rd_x`=1 one cycle, `ch_sel`=channel, counter loaded LEAD−1; count down, then ISSUE.
- ISSUE: `pi_sta`=1 one cycle; go WAIT.
- WAIT: on `pi_done`, clear channel's `pend` bit, go NEXT.
- NEXT (one cycle): `wr_en`=1, `wr_ch`=finished channel; if `pend`≠0 same cycle `rd_x`=1 with `ch_sel`=next lowest set bit, go LEAD (counter LEAD−1); else `step_done`=1, `busy`=0, go IDLE.
- `ch_sel` holds until next `rd_x`; channels served in ascending index order.
- `step_start` while `busy`: ignored, no queueing. `pi_done` outside WAIT: ignored.
- Reset (any time, including mid-step): all outputs 0, `pend`=0, `err`=0, state IDLE; no partial commit.

## Timing
- `step_start` at cycle c → first `rd_x` at c+1 (t0).
- `pi_sta` at t0+LEAD; with nominal core, `pi_done` at t0+LEAD+LAT; `wr_en` and next `rd_x` at t0+LEAD+LAT+1.
- Per-channel period LEAD+LAT+1 (43 at defaults); k enabled channels → `step_done` at c+1+k·43.
- `busy` rises c+1, falls with `step_done`.
- Empty mask: `step_done` at c+1, `busy` never rises.
- All outputs registered.

## Configuration
- `PI_SCHED_WDOG_EN` defined: counter runs in WAIT from `pi_sta`; if `pi_done` absent for TO_CYC cycles, `err` set (sticky until reset), `step_done` pulses same cycle, no `wr_en`, remaining `pend` dropped, state IDLE. A `pi_done` arriving exactly on the TO_CYC cycle counts as done (no error).
- Undefined: WAIT indefinitely; `err` tied 0; no watchdog counter.

## Structure
- Shared package `pi_sched_pkg`: state encoding constants, default LEAD/LAT/TO_CYC, clog2 helper.
- One sub-module: `pi_sched_next_ch` — combinational lowest-set-bit finder over `pend` returning index and valid.

## Test plan
- N_CH=4, mask 4'b1111, `step_start` at cycle 0, core model done 27 after sta → `rd_x` at 1/44/87/130, `pi_sta` at 16/59/102/145, `wr_ch` 0,1,2,3, `step_done` at 173.
- mask 4'b1010 → only channels 1,3 served, `ch_sel` 1 then 3, `step_done` at 87.
- mask 4'b0000 → `step_done` at 1, no `rd_x`/`pi_sta`/`wr_en`, `busy` stays 0.
- `rst_user` at cycle 20 of a full step → all outputs 0 immediately; new `step_start` restarts at channel 0 with `rd_x` one cycle later.
- Watchdog build, TO_CYC=63, core withholds `pi_done` → `err`=1 and `step_done` 63 cycles after `pi_sta`, no `wr_en`; non-watchdog build hangs with `busy`=1.
- `step_start` during busy and `pi_done` injected during LEAD → both ignored; schedule identical to scenario 1.
